// File: rtl/seq_det_pkg.sv
// Shared "101" detector step, used by the time-shared scheduler and by
// standalone single-channel detectors.
package seq_det_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    typedef struct packed {
        logic [1:0] next;
        logic       hit;
    } det_res_t;

    // Mealy step: 2'b11 is illegal and recovers exactly like S0.
    function automatic det_res_t det_step(input logic [1:0] state, input logic b);
        det_res_t res;
        res.hit = 1'b0;
        case (state)
            S0:      res.next = b ? S1 : S0;
            S1:      res.next = b ? S1 : S2;
            S2: begin
                res.next = b ? S1 : S0;
                res.hit  = b;
            end
            default: res.next = b ? S1 : S0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found scanning from ptr upwards, modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [2*N-1:0] rot_full_s;
    logic [2*N-1:0] gnt_full_s;
    logic [N-1:0]   pick_s;
    logic           found_s;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        rot_full_s = {req, req} >> ptr;
        pick_s     = '0;
        found_s    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && rot_full_s[i]) begin
                pick_s[i] = 1'b1;
                found_s   = 1'b1;
            end else begin
                found_s   = found_s;
            end
        end
        gnt_full_s = {pick_s, pick_s} << ptr;
        gnt        = gnt_full_s[2*N-1:N];
    end

endmodule

// File: rtl/seq_detect_sched.sv
// One "101" detector time-shared across NCH serial channels; each channel's
// detector state is kept in its own context slot between grants.
module seq_detect_sched
    import seq_det_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   bit_in,
    input  logic [NCH-1:0]   clr,
    output logic [NCH-1:0]   gnt,
    output logic             hit_vld,
    output logic [CH_W-1:0]  hit_ch,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [1:0]       ctx_r [NCH];
    logic [CH_W-1:0]  rr_ptr_r;
    logic             hit_vld_r;
    logic [CH_W-1:0]  hit_ch_r;
    logic [CNT_W-1:0] hit_cnt_r;

    logic [NCH-1:0]   elig_s;
    logic [NCH-1:0]   arb_gnt_s;
    logic [CH_W-1:0]  gnt_idx_s;
    logic [CH_W-1:0]  ptr_next_s;
    logic             gnt_any_s;
    det_res_t         step_s;

    // A channel being cleared is not eligible; its bit is dropped.
    assign elig_s = req & ~clr;

    rr_arbiter #(.N(NCH), .PW(CH_W)) u_arb (
        .req (elig_s),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt_s)
    );

    assign gnt     = reset ? '0 : arb_gnt_s;
    assign hit_vld = hit_vld_r;
    assign hit_ch  = hit_ch_r;
    assign hit_cnt = hit_cnt_r;

    // Encode the one-hot grant and run the shared detector on the granted context.
    always_comb begin
        gnt_idx_s = '0;
        for (int i = 0; i < NCH; i++) begin
            gnt_idx_s = gnt_idx_s | (arb_gnt_s[i] ? CH_W'(i) : CH_W'(0));
        end
        gnt_any_s  = |arb_gnt_s;
        step_s     = det_step(ctx_r[gnt_idx_s], bit_in[gnt_idx_s]);
        ptr_next_s = (gnt_idx_s == CH_W'(NCH - 1)) ? CH_W'(0) : gnt_idx_s + CH_W'(1);
    end

    // Context slots, round-robin pointer and registered hit reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_r[i] <= S0;
            end
            rr_ptr_r  <= '0;
            hit_vld_r <= 1'b0;
            hit_ch_r  <= '0;
            hit_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    ctx_r[i] <= S0;
                end
            end
            if (gnt_any_s) begin
                ctx_r[gnt_idx_s] <= step_s.next;
                rr_ptr_r         <= ptr_next_s;
            end
            hit_vld_r <= gnt_any_s & step_s.hit;
            if (gnt_any_s && step_s.hit) begin
                hit_ch_r <= gnt_idx_s;
                if (hit_cnt_r != '1) begin
                    hit_cnt_r <= hit_cnt_r + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed table, corner sequences and random
// traffic checked against a bit-history reference model.
module tb_seq_detect_sched;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] clr;
    logic [3:0] gnt;
    logic       hit_vld;
    logic [1:0] hit_ch;
    logic [7:0] hit_cnt;
    logic [3:0] gnt2;
    logic       hit_vld2;
    logic [1:0] hit_ch2;
    logic [1:0] hit_cnt2;

    seq_detect_sched #(.NCH(4), .CH_W(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr(clr),
        .gnt(gnt), .hit_vld(hit_vld), .hit_ch(hit_ch), .hit_cnt(hit_cnt)
    );

    seq_detect_sched #(.NCH(4), .CH_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr(clr),
        .gnt(gnt2), .hit_vld(hit_vld2), .hit_ch(hit_ch2), .hit_cnt(hit_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: per-channel history of accepted bits since clear/reset.
    int         ptr_m;
    logic [2:0] hist_m [4];
    int         len_m  [4];
    logic       hv_m;
    logic [1:0] hc_m;
    int         hits_m;
    logic [3:0] obs_gnt;

    typedef struct {
        logic       rst_before;
        logic [3:0] req;
        logic [3:0] bits;
        logic [3:0] exp_gnt;
        logic       exp_hit;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl [10];
    int   exp5 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ptr_m  = 0;
        hv_m   = 1'b0;
        hc_m   = 2'd0;
        hits_m = 0;
        for (int i = 0; i < 4; i++) begin
            hist_m[i] = 3'b000;
            len_m[i]  = 0;
        end
    endtask

    task automatic do_reset();
        req    = 4'b1111;
        bit_in = 4'b1111;
        clr    = 4'b0000;
        reset  = 1'b1;
        #1;
        check("gnt_in_reset", {28'd0, gnt}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hit_vld", {31'd0, hit_vld}, 32'd0);
        check("rst_hit_ch", {30'd0, hit_ch}, 32'd0);
        check("rst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] e;
        logic [3:0] exp_g;
        int         k;
        int         cnt8;
        int         cnt2;
        req    = r;
        bit_in = b;
        clr    = c;
        #1;
        e     = r & ~c;
        exp_g = 4'b0000;
        k     = -1;
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (ptr_m + i) % 4;
            if (k < 0 && e[idx[1:0]]) k = idx;
        end
        if (k >= 0) exp_g[k[1:0]] = 1'b1;
        obs_gnt = gnt;
        check("gnt", {28'd0, gnt}, {28'd0, exp_g});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                hist_m[i] = 3'b000;
                len_m[i]  = 0;
            end
        end
        hv_m = 1'b0;
        if (k >= 0) begin
            hist_m[k[1:0]] = {hist_m[k[1:0]][1:0], b[k[1:0]]};
            len_m[k[1:0]]  = len_m[k[1:0]] + 1;
            if (len_m[k[1:0]] >= 3 && hist_m[k[1:0]] == 3'b101) begin
                hv_m   = 1'b1;
                hc_m   = k[1:0];
                hits_m = hits_m + 1;
            end
            ptr_m = (k + 1) % 4;
        end
        cnt8 = (hits_m > 255) ? 255 : hits_m;
        cnt2 = (hits_m > 3) ? 3 : hits_m;
        check("hit_vld", {31'd0, hit_vld}, {31'd0, hv_m});
        check("hit_ch", {30'd0, hit_ch}, {30'd0, hc_m});
        check("hit_cnt", {24'd0, hit_cnt}, cnt8);
        check("hit_cnt_w2", {30'd0, hit_cnt2}, cnt2);
    endtask

    initial begin
        int nh;
        reset  = 1'b1;
        req    = 4'b0000;
        bit_in = 4'b0000;
        clr    = 4'b0000;
        model_reset();

        // Channel 0 overlap detection, then a full round-robin rotation.
        tbl[0] = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 8'd1};
        tbl[3] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 8'd1};
        tbl[4] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 8'd2};
        tbl[5] = '{1'b1, 4'b1111, 4'b1111, 4'b0001, 1'b0, 8'd0};
        tbl[6] = '{1'b0, 4'b1111, 4'b1111, 4'b0010, 1'b0, 8'd0};
        tbl[7] = '{1'b0, 4'b1111, 4'b1111, 4'b0100, 1'b0, 8'd0};
        tbl[8] = '{1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b0, 8'd0};
        tbl[9] = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 1'b0, 8'd0};
        exp5   = '{1, 2, 3, 3, 3};

        for (int v = 0; v < 10; v++) begin
            if (tbl[v].rst_before) do_reset();
            cycle(tbl[v].req, tbl[v].bits, 4'b0000);
            check("tbl_gnt", {28'd0, obs_gnt}, {28'd0, tbl[v].exp_gnt});
            check("tbl_hit", {31'd0, hit_vld}, {31'd0, tbl[v].exp_hit});
            check("tbl_cnt", {24'd0, hit_cnt}, {24'd0, tbl[v].exp_cnt});
            if (tbl[v].exp_hit) check("tbl_ch", {30'd0, hit_ch}, 32'd0);
        end

        // Interleaved ch1 (1,0,1) and ch2 (0,1,1); ch2 must be left in S1.
        do_reset();
        nh = 0;
        for (int c = 0; c < 6; c++) begin
            logic [2:0] s1;
            logic [2:0] s2;
            s1 = 3'b101;
            s2 = 3'b110;
            cycle(4'b0110, {1'b0, s2[c/2], s1[c/2], 1'b0}, 4'b0000);
            if (hit_vld) nh++;
        end
        check("t3_hits", nh, 32'd1);
        check("t3_ch", {30'd0, hit_ch}, 32'd1);
        cycle(4'b0100, 4'b0000, 4'b0000);
        cycle(4'b0100, 4'b0100, 4'b0000);
        check("t3_ctx2_hit", {31'd0, hit_vld}, 32'd1);
        check("t3_ctx2_ch", {30'd0, hit_ch}, 32'd2);

        // Clear on ch3 mid-pattern drops the bit and restarts the context.
        do_reset();
        cycle(4'b1000, 4'b1000, 4'b0000);
        cycle(4'b1000, 4'b0000, 4'b0000);
        cycle(4'b1000, 4'b1000, 4'b1000);
        check("t4_gnt_clr", {28'd0, obs_gnt}, 32'd0);
        cycle(4'b1000, 4'b1000, 4'b0000);
        check("t4_no_hit", {31'd0, hit_vld}, 32'd0);

        // Five hits on ch0: the 2-bit counter saturates at 3.
        do_reset();
        nh = 0;
        for (int i = 0; i < 11; i++) begin
            cycle(4'b0001, {3'b000, (i % 2 == 0) ? 1'b1 : 1'b0}, 4'b0000);
            if (hit_vld) begin
                if (nh < 5) check("t5_cnt2", {30'd0, hit_cnt2}, exp5[nh]);
                nh++;
            end
        end
        check("t5_hits", nh, 32'd5);
        check("t5_cnt8", {24'd0, hit_cnt}, 32'd5);

        // Asynchronous reset between "10" and "1" on ch0.
        cycle(4'b0001, 4'b0001, 4'b0000);
        cycle(4'b0001, 4'b0000, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check("t6_cnt_async", {24'd0, hit_cnt}, 32'd0);
        check("t6_cnt2_async", {30'd0, hit_cnt2}, 32'd0);
        check("t6_gnt_async", {28'd0, gnt}, 32'd0);
        check("t6_vld_async", {31'd0, hit_vld}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle(4'b0001, 4'b0001, 4'b0000);
        check("t6_no_hit", {31'd0, hit_vld}, 32'd0);

        // Random traffic with occasional clears.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            logic [3:0] b;
            logic [3:0] c;
            r = 4'($urandom_range(0, 15));
            b = 4'($urandom);
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cycle(r, b, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
